// File: rtl/wave_frame_sequencer_pkg.sv
// Shared types and sizes for the wave mesh sequencer slice.
// Optional watchdog build macro: WAVE_SEQ_WATCHDOG_EN.
package wave_frame_sequencer_pkg;

    localparam int V_WIDTH         = 16;
    localparam int PSI_WIDTH       = 16;
    localparam int SEQ_COUNT_WIDTH = 16;

    // {im, re} so a raw 32-bit load word maps straight onto it
    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } complex_t;

    typedef enum logic [1:0] {
        LOAD_POT = 2'd0,
        LOAD_PSI = 2'd1,
        EVOLVE   = 2'd2,
        SCAN     = 2'd3
    } seq_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_SCAN_ADDR,
        S_SCAN_HOLD,
        S_FIN
    } seq_state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wave_frame_sequencer_if.sv
// Host-side command, load and scan streams of the sequencer.
// Optional watchdog build macro: WAVE_SEQ_WATCHDOG_EN.
interface wave_frame_sequencer_if #(
    parameter int MESH_X = 8,
    parameter int MESH_Y = 8
);
    import wave_frame_sequencer_pkg::*;

    localparam int XW = addr_w(MESH_X);
    localparam int YW = addr_w(MESH_Y);

    logic                       cmd_valid;
    logic                       cmd_ready;
    seq_op_e                    cmd_op;
    logic [SEQ_COUNT_WIDTH-1:0] cmd_count;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [PSI_WIDTH-1:0] out_mag;
    logic [XW-1:0]        out_x;
    logic [YW-1:0]        out_y;
    logic                 out_last;

    modport master (
        output cmd_valid, cmd_op, cmd_count,
        input  cmd_ready,
        output ld_valid, ld_data,
        input  ld_ready,
        input  out_valid, out_mag, out_x, out_y, out_last,
        output out_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count,
        output cmd_ready,
        input  ld_valid, ld_data,
        output ld_ready,
        output out_valid, out_mag, out_x, out_y, out_last,
        input  out_ready
    );

endinterface

// File: rtl/wave_frame_sequencer_raster.sv
// Raster x/y cell counter shared by the load and scan paths.
// Optional watchdog build macro: WAVE_SEQ_WATCHDOG_EN.
module wave_raster_addr
    import wave_frame_sequencer_pkg::*;
#(
    parameter int MESH_X = 8,
    parameter int MESH_Y = 8,
    localparam int XW = addr_w(MESH_X),
    localparam int YW = addr_w(MESH_Y)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(MESH_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(MESH_Y - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    // x fastest, wrap by compare so non-power-of-2 meshes work
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_frame_sequencer.sv
// Command sequencer owning one wave_mesh's write, enable and read ports.
// Optional frame_done watchdog build macro: WAVE_SEQ_WATCHDOG_EN.
module wave_frame_sequencer
    import wave_frame_sequencer_pkg::*;
#(
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8,
    parameter int READ_LAT = 1,
`ifdef WAVE_SEQ_WATCHDOG_EN
    parameter int WDOG_CYCLES = 4096,
`endif
    localparam int XW = addr_w(MESH_X),
    localparam int YW = addr_w(MESH_Y)
) (
    input  logic                       clk,
    input  logic                       rst,
    wave_frame_sequencer_if.slave      host,
    output logic                       mesh_enable,
    output logic                       mesh_pot_we,
    output logic [XW-1:0]              mesh_pot_x,
    output logic [YW-1:0]              mesh_pot_y,
    output logic [V_WIDTH-1:0]         mesh_pot_data,
    output logic                       mesh_psi_we,
    output logic [XW-1:0]              mesh_psi_x,
    output logic [YW-1:0]              mesh_psi_y,
    output complex_t                   mesh_psi_data,
    output logic [XW-1:0]              mesh_read_x,
    output logic [YW-1:0]              mesh_read_y,
    input  logic [PSI_WIDTH-1:0]       mesh_read_magnitude,
    input  logic                       mesh_frame_done,
    output logic                       done,
    output logic [SEQ_COUNT_WIDTH-1:0] frames_run,
    output logic                       err_timeout
);

    localparam int LW = addr_w(READ_LAT + 1);

    seq_state_e                 state_q;
    seq_state_e                 state_d;
    seq_op_e                    op_q;
    logic [SEQ_COUNT_WIDTH-1:0] count_q;
    logic [SEQ_COUNT_WIDTH-1:0] frames_inc;
    logic [LW-1:0]              lat_q;
    logic [XW-1:0]              ax;
    logic [YW-1:0]              ay;
    logic                       a_last;
    logic                       accept;
    logic                       ld_hs;
    logic                       out_hs;
    logic                       frame_hit;
    logic                       lat_done;
    logic                       wdog_hit;

    logic                 cmd_ready_c;
    logic                 ld_ready_c;
    logic                 out_valid_c;
    logic [PSI_WIDTH-1:0] out_mag_c;
    logic [XW-1:0]        out_x_c;
    logic [YW-1:0]        out_y_c;
    logic                 out_last_c;

    assign accept     = (state_q == S_IDLE) && host.cmd_valid;
    assign ld_hs      = (state_q == S_LOAD) && host.ld_valid;
    assign out_hs     = (state_q == S_SCAN_HOLD) && host.out_ready;
    assign frame_hit  = (state_q == S_WAIT) && mesh_frame_done;
    assign frames_inc = (&frames_run) ? frames_run : frames_run + 1'b1;
    assign lat_done   = (lat_q == LW'(READ_LAT - 1));

    wave_raster_addr #(
        .MESH_X (MESH_X),
        .MESH_Y (MESH_Y)
    ) u_addr (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .adv  (ld_hs || out_hs),
        .x    (ax),
        .y    (ay),
        .last (a_last)
    );

`ifdef WAVE_SEQ_WATCHDOG_EN
    localparam int WW = addr_w(WDOG_CYCLES);

    logic [WW-1:0] wdog_q;

    // cycles spent waiting on the current frame
    always_ff @(posedge clk) begin
        if (rst || state_q != S_WAIT || mesh_frame_done) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign wdog_hit = (state_q == S_WAIT) && !mesh_frame_done &&
                      (wdog_q == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    assign err_timeout = wdog_hit;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    case (host.cmd_op)
                        LOAD_POT, LOAD_PSI: state_d = S_LOAD;
                        EVOLVE: state_d = (host.cmd_count == '0) ?
                                          S_FIN : S_KICK;
                        default: state_d = S_SCAN_ADDR;
                    endcase
                end
            end
            S_LOAD: begin
                if (ld_hs && a_last) begin
                    state_d = S_FIN;
                end
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: begin
                if (frame_hit) begin
                    state_d = (frames_inc == count_q) ? S_FIN : S_KICK;
                end else if (wdog_hit) begin
                    state_d = S_FIN;
                end
            end
            S_SCAN_ADDR: begin
                if (lat_done) begin
                    state_d = S_SCAN_HOLD;
                end
            end
            S_SCAN_HOLD: begin
                if (out_hs) begin
                    state_d = a_last ? S_FIN : S_SCAN_ADDR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state-decoded outputs; scan payload only visible while held
    always_comb begin
        cmd_ready_c = 1'b0;
        ld_ready_c  = 1'b0;
        mesh_enable = 1'b0;
        out_valid_c = 1'b0;
        done        = 1'b0;
        out_mag_c   = '0;
        out_x_c     = '0;
        out_y_c     = '0;
        out_last_c  = 1'b0;
        case (state_q)
            S_IDLE: cmd_ready_c = 1'b1;
            S_LOAD: ld_ready_c  = 1'b1;
            S_KICK: mesh_enable = 1'b1;
            S_SCAN_HOLD: begin
                out_valid_c = 1'b1;
                out_mag_c   = mesh_read_magnitude;
                out_x_c     = ax;
                out_y_c     = ay;
                out_last_c  = a_last;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign host.cmd_ready = cmd_ready_c;
    assign host.ld_ready  = ld_ready_c;
    assign host.out_valid = out_valid_c;
    assign host.out_mag   = out_mag_c;
    assign host.out_x     = out_x_c;
    assign host.out_y     = out_y_c;
    assign host.out_last  = out_last_c;
    assign mesh_read_x    = ax;
    assign mesh_read_y    = ay;

    // command latch, frame tally and read-latency timer
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= LOAD_POT;
            count_q    <= '0;
            frames_run <= '0;
            lat_q      <= '0;
        end else begin
            if (accept) begin
                op_q    <= host.cmd_op;
                count_q <= host.cmd_count;
                if (host.cmd_op == EVOLVE) begin
                    frames_run <= '0;
                end
            end else if (frame_hit) begin
                frames_run <= frames_inc;
            end
            lat_q <= (state_q == S_SCAN_ADDR && !lat_done) ?
                     lat_q + 1'b1 : '0;
        end
    end

    // one mesh write per load handshake, presented on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mesh_pot_we   <= 1'b0;
            mesh_pot_x    <= '0;
            mesh_pot_y    <= '0;
            mesh_pot_data <= '0;
            mesh_psi_we   <= 1'b0;
            mesh_psi_x    <= '0;
            mesh_psi_y    <= '0;
            mesh_psi_data <= '0;
        end else begin
            mesh_pot_we <= ld_hs && (op_q == LOAD_POT);
            mesh_psi_we <= ld_hs && (op_q == LOAD_PSI);
            if (ld_hs) begin
                mesh_pot_x    <= ax;
                mesh_pot_y    <= ay;
                mesh_pot_data <= host.ld_data[V_WIDTH-1:0];
                mesh_psi_x    <= ax;
                mesh_psi_y    <= ay;
                mesh_psi_data <= complex_t'(host.ld_data);
            end
        end
    end

endmodule

// File: tb/tb_wave_frame_sequencer.sv
// Randomized bench for wave_frame_sequencer with a simple mesh model.
// Watchdog checks compile in with WAVE_SEQ_WATCHDOG_EN.
module tb_wave_frame_sequencer;
    import wave_frame_sequencer_pkg::*;

    localparam int MX = 8;
    localparam int MY = 8;
    localparam int N  = MX * MY;
    localparam int XB = $clog2(MX);
    localparam int YB = $clog2(MY);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wave_frame_sequencer_if #(.MESH_X(MX), .MESH_Y(MY)) host ();

    logic                       mesh_enable;
    logic                       mesh_pot_we;
    logic [XB-1:0]              mesh_pot_x;
    logic [YB-1:0]              mesh_pot_y;
    logic [V_WIDTH-1:0]         mesh_pot_data;
    logic                       mesh_psi_we;
    logic [XB-1:0]              mesh_psi_x;
    logic [YB-1:0]              mesh_psi_y;
    complex_t                   mesh_psi_data;
    logic [XB-1:0]              mesh_read_x;
    logic [YB-1:0]              mesh_read_y;
    logic [PSI_WIDTH-1:0]       mesh_read_magnitude;
    logic                       mesh_frame_done = 1'b0;
    logic                       done;
    logic [SEQ_COUNT_WIDTH-1:0] frames_run;
    logic                       err_timeout;

    wave_frame_sequencer #(
        .MESH_X   (MX),
        .MESH_Y   (MY),
`ifdef WAVE_SEQ_WATCHDOG_EN
        .WDOG_CYCLES (100),
`endif
        .READ_LAT (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host                (host.slave),
        .mesh_enable         (mesh_enable),
        .mesh_pot_we         (mesh_pot_we),
        .mesh_pot_x          (mesh_pot_x),
        .mesh_pot_y          (mesh_pot_y),
        .mesh_pot_data       (mesh_pot_data),
        .mesh_psi_we         (mesh_psi_we),
        .mesh_psi_x          (mesh_psi_x),
        .mesh_psi_y          (mesh_psi_y),
        .mesh_psi_data       (mesh_psi_data),
        .mesh_read_x         (mesh_read_x),
        .mesh_read_y         (mesh_read_y),
        .mesh_read_magnitude (mesh_read_magnitude),
        .mesh_frame_done     (mesh_frame_done),
        .done                (done),
        .frames_run          (frames_run),
        .err_timeout         (err_timeout)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mesh model: storage, event tallies, 1-cycle read latency
    logic [31:0] ld_buf  [N];
    logic [31:0] psi_mem [N];
    logic [15:0] mag_mem [N];
    logic [31:0] pot_log [$];
    logic [15:0] rd_q = '0;
    int cyc = 0, en_tot = 0, done_tot = 0, err_tot = 0, psi_tot = 0;
    int en_last = 0, err_cyc = 0;

    assign mesh_read_magnitude = rd_q;

    always @(posedge clk) begin
        rd_q <= mag_mem[int'(mesh_read_y) * MX + int'(mesh_read_x)];
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (mesh_enable) begin
                en_tot++;
                en_last = cyc;
            end
            if (done) done_tot++;
            if (err_timeout) begin
                err_tot++;
                err_cyc = cyc;
            end
            if (mesh_pot_we)
                pot_log.push_back({10'd0, mesh_pot_y, mesh_pot_x,
                                   mesh_pot_data});
            if (mesh_psi_we) begin
                psi_tot++;
                psi_mem[int'(mesh_psi_y) * MX + int'(mesh_psi_x)] =
                    mesh_psi_data;
            end
        end
    end

    // frame_done arrives fd_delay cycles after each enable
    bit fd_en    = 1'b1;
    bit fd_force = 1'b0;
    int fd_delay = 10;

    always begin
        int fd_cnt;
        @(posedge clk);
        #2;
        mesh_frame_done = 1'b0;
        if (rst) begin
            fd_cnt = 0;
        end else begin
            if (fd_cnt > 0) begin
                fd_cnt--;
                if (fd_cnt == 0) mesh_frame_done = 1'b1;
            end
            if (fd_force) mesh_frame_done = 1'b1;
            if (mesh_enable && fd_en) fd_cnt = fd_delay;
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"},
            {23'd0, host.cmd_ready, host.ld_ready, mesh_enable,
             host.out_valid, host.out_last, done, err_timeout,
             mesh_pot_we, mesh_psi_we},
            32'h100);
        chk({tag, "_addr"},
            {8'd0, mesh_read_x, mesh_read_y, host.out_x, host.out_y,
             mesh_pot_x, mesh_pot_y, mesh_psi_x, mesh_psi_y}, 0);
        chk({tag, "_data"}, {mesh_pot_data, host.out_mag}, 0);
        chk({tag, "_psi"}, mesh_psi_data, 0);
        chk({tag, "_frames"}, frames_run, 0);
    endtask

    task automatic send(input seq_op_e op, input int cnt);
        chk("cmd_ready", host.cmd_ready, 1);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_count = cnt[15:0];
        cyc1();
        host.cmd_valid = 1'b0;
        host.cmd_count = 16'($urandom);
        chk("cmd_busy", host.cmd_ready, 0);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        while (!done && n < lim) begin
            cyc1();
            n++;
        end
        chk(tag, done, 1);
        cyc1();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, host.cmd_ready, 1);
    endtask

    task automatic load(input bit toggle);
        int  i  = 0;
        int  n  = 0;
        bit  ph = 1'b1;
        bit  hs;
        while (i < N && n < 2000) begin
            host.ld_valid = toggle ? ph : ($urandom_range(0, 3) != 0);
            ph = ~ph;
            host.ld_data = host.ld_valid ? ld_buf[i] : $urandom;
            hs = host.ld_valid && host.ld_ready;
            cyc1();
            n++;
            if (hs) i++;
        end
        host.ld_valid = 1'b0;
        chk("ld_words", i, N);
    endtask

    task automatic evolve(input string tag, input int cnt, input int dly);
        int e0 = en_tot;
        int d0 = done_tot;
        fd_delay = dly;
        send(EVOLVE, cnt);
        wait_done(tag, 40 * cnt + 20);
        chk({tag, "_en"}, en_tot - e0, cnt);
        chk({tag, "_frames"}, frames_run, cnt);
        chk({tag, "_ndone"}, done_tot - d0, 1);
    endtask

    initial begin
        int p0, s0, d0, e0, f0, beat, n, st, cnt;
        bit hs, stalled;
        logic [31:0] exp;

        host.cmd_valid = 1'b0;
        host.cmd_op    = LOAD_POT;
        host.cmd_count = '0;
        host.ld_valid  = 1'b0;
        host.ld_data   = '0;
        host.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            psi_mem[i] = '0;
            mag_mem[i] = '0;
        end

        repeat (3) cyc1();
        chk_idle("rst0");
        rst = 1'b0;
        cyc1();
        chk_idle("idle0");

        // potential load with a barrier column, valid every other cycle
        for (int i = 0; i < N; i++) begin
            if (i % MX == 4 && i / MX >= 2 && i / MX <= 5)
                ld_buf[i] = 32'd1024;
            else
                ld_buf[i] = {$urandom_range(0, 65535), 16'($urandom)};
        end
        p0 = pot_log.size();
        s0 = psi_tot;
        d0 = done_tot;
        send(LOAD_POT, $urandom);
        load(1'b1);
        wait_done("pot_done", 0);
        chk("pot_cnt", pot_log.size() - p0, N);
        for (int i = 0; i < N; i++) begin
            exp = ((i / MX) << (16 + XB)) | ((i % MX) << 16) |
                  {16'd0, ld_buf[i][15:0]};
            if (p0 + i < pot_log.size()) chk("pot_cell", pot_log[p0 + i], exp);
        end
        chk("pot_no_psi", psi_tot - s0, 0);
        chk("pot_ndone", done_tot - d0, 1);

        // wavefunction load with random gaps
        for (int i = 0; i < N; i++) ld_buf[i] = $urandom;
        p0 = pot_log.size();
        s0 = psi_tot;
        send(LOAD_PSI, 0);
        load(1'b0);
        wait_done("psi_done", 0);
        chk("psi_cnt", psi_tot - s0, N);
        chk("psi_no_pot", pot_log.size() - p0, 0);
        for (int i = 0; i < N; i++) chk("psi_cell", psi_mem[i], ld_buf[i]);

        // evolutions
        fd_en = 1'b1;
        evolve("ev3", 3, 10);
        for (int k = 0; k < 3; k++) begin
            cnt = $urandom_range(1, 5);
            evolve("ev_rnd", cnt, $urandom_range(1, 6));
        end

        // frame_done in IDLE is ignored
        f0 = frames_run;
        fd_force = 1'b1;
        cyc1();
        fd_force = 1'b0;
        repeat (3) cyc1();
        chk("fd_idle", frames_run, f0);

        // zero-frame evolve finishes at once
        e0 = en_tot;
        send(EVOLVE, 0);
        chk("ev0_done", done, 1);
        chk("ev0_frames", frames_run, 0);
        cyc1();
        chk("ev0_idle", host.cmd_ready, 1);
        chk("ev0_en", en_tot - e0, 0);

        // raster scan with a forced stall mid-stream
        for (int i = 0; i < N; i++) mag_mem[i] = 16'($urandom);
        d0 = done_tot;
        send(SCAN, $urandom);
        beat = 0;
        n = 0;
        st = 0;
        stalled = 1'b0;
        while (beat < N && n < 3000) begin
            if (beat == 30 && !stalled) begin
                stalled = 1'b1;
                st = 5;
            end
            host.out_ready = (st > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (st == 1) chk("stall_valid", host.out_valid, 1);
            if (host.out_valid) begin
                chk(st > 0 ? "stall_mag" : "scan_mag", host.out_mag,
                    mag_mem[beat]);
                chk("scan_xy", {host.out_y, host.out_x},
                    ((beat / MX) << XB) | (beat % MX));
                chk("scan_last", host.out_last, beat == N - 1);
            end
            hs = host.out_valid && host.out_ready;
            cyc1();
            n++;
            if (st > 0) st--;
            if (hs) beat++;
        end
        host.out_ready = 1'b0;
        chk("scan_beats", beat, N);
        wait_done("scan_done", 0);
        chk("scan_ndone", done_tot - d0, 1);

        // reset while waiting on a frame
        fd_delay = 3;
        send(EVOLVE, 5);
        n = 0;
        while (frames_run != 2 && n < 100) begin
            cyc1();
            n++;
        end
        chk("rst_pre", frames_run, 2);
        fd_en = 1'b0;
        repeat (2) cyc1();
        rst = 1'b1;
        cyc1();
        chk_idle("rst_wait");
        rst = 1'b0;
        fd_en = 1'b1;
        cyc1();
        evolve("post_rst", 1, 2);

`ifdef WAVE_SEQ_WATCHDOG_EN
        // no frame_done ever: watchdog aborts the evolve
        fd_en = 1'b0;
        e0 = en_tot;
        d0 = done_tot;
        f0 = err_tot;
        send(EVOLVE, 2);
        wait_done("wd_done", 300);
        chk("wd_err", err_tot - f0, 1);
        chk("wd_lat", err_cyc - en_last, 100);
        chk("wd_en", en_tot - e0, 1);
        chk("wd_frames", frames_run, 0);
        chk("wd_ndone", done_tot - d0, 1);
        fd_en = 1'b1;
`else
        chk("no_timeout", err_tot, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
